// File: rtl/gray_pkg.sv
// gray_pkg: shared width limit and Gray/binary conversion helpers
package gray_pkg;
  localparam int N_MAX = 32;
  function automatic logic [N_MAX-1:0] bin2gray(input logic [N_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [N_MAX-1:0] gray2bin(input logic [N_MAX-1:0] g);
    logic [N_MAX-1:0] b;
    b[N_MAX-1] = g[N_MAX-1];
    for (int i = N_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_decode.sv
// gray_decode: combinational N-bit Gray-to-binary decoder
module gray_decode
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g_i,
  output logic [N-1:0] b_o
);
  // zero-extension is harmless: leading zeros decode to leading zeros
  always_comb b_o = N'(gray2bin(N_MAX'(g_i)));
endmodule

// File: rtl/gray_counter_n_bit.sv
// gray_counter_n_bit: up/down loadable Gray counter with binary view; GRAY_COUNTER_SATURATE_EN selects saturation instead of wrap
module gray_counter_n_bit
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] D,
  output logic [N-1:0] G,
  output logic [N-1:0] B,
  output logic         wrap,
  output logic         tc
);
  logic [N-1:0] b_q, b_d, g_q, g_d, step, dec_b;
  logic         wrap_q, wrap_d, at_end;
  gray_decode #(.N(N)) u_dec (.g_i(g_q), .b_o(dec_b));
  // next state: load beats en; wrap flags a step taken at the end of range
  always_comb begin
    at_end = up ? &b_q : ~|b_q;
`ifdef GRAY_COUNTER_SATURATE_EN
    step = at_end ? b_q : (up ? b_q + 1'b1 : b_q - 1'b1);
`else
    step = up ? b_q + 1'b1 : b_q - 1'b1;
`endif
    b_d    = load ? D : en ? step : b_q;
    wrap_d = !load && en && at_end;
    g_d    = N'(bin2gray(N_MAX'(b_d)));
  end
  // all state registers, reset has top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end
  assign B    = b_q;
  assign G    = g_q;
  assign wrap = wrap_q;
  assign tc   = up ? &dec_b : ~|dec_b;
endmodule

// File: tb/tb_gray_counter_n_bit.sv
// tb_gray_counter_n_bit: directed and random checks of the 4-bit Gray counter
module tb_gray_counter_n_bit;
`ifdef GRAY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] D = '0;
  logic [3:0] G, B;
  logic wrap, tc;
  int vecs = 0, errs = 0;
  logic [3:0] bm = '0;
  logic wm = 1'b0;
  logic [3:0] gtab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  gray_counter_n_bit #(.N(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(D),
    .G(G), .B(B), .wrap(wrap), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gm(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input logic r, input logic e, input logic u, input logic l, input logic [3:0] d);
    logic [3:0] pg;
    logic stepped, end_c;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; D = d;
    pg = G;
    stepped = 1'b0;
    end_c = u ? (bm == 4'hF) : (bm == 4'h0);
    @(posedge clk);
    #1;
    if (r) begin
      bm = '0; wm = 1'b0;
    end else if (l) begin
      bm = d; wm = 1'b0;
    end else if (e) begin
      wm = end_c;
      if (!(SAT && end_c)) begin
        bm = u ? 4'(bm + 4'd1) : 4'(bm - 4'd1);
        stepped = 1'b1;
      end
    end else wm = 1'b0;
    chk("model_b", B, bm);
    chk("model_g", G, gm(bm));
    chk("model_wrap", wrap, wm);
    chk("model_tc", tc, u ? (bm == 4'hF) : (bm == 4'h0));
    if (stepped) chk("one_bit_change", $countones(G ^ pg), 1);
  endtask

  initial begin
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 4'hA);
    chk("rst_b", B, 0);
    chk("rst_g", G, 0);
    chk("rst_wrap", wrap, 0);
    for (int i = 0; i < 15; i++) begin
      tick(0, 1, 1, 0, 0);
      chk("up_b", B, i + 1);
      chk("up_g", G, gtab[i]);
      chk("up_wrap", wrap, 0);
    end
    chk("tc_at_15", tc, 1);
    tick(0, 1, 1, 0, 0);
    chk("wrap_b", B, SAT ? 15 : 0);
    chk("wrap_g", G, SAT ? 8 : 0);
    chk("wrap_pulse", wrap, 1);
    tick(0, 0, 1, 0, 0);
    chk("idle_wrap_clear", wrap, 0);
    chk("idle_hold_b", B, SAT ? 15 : 0);
    tick(0, 1, 1, 1, 4'b0101);
    chk("load_b", B, 5);
    chk("load_g", G, 4'b0111);
    chk("load_wrap", wrap, 0);
    tick(0, 1, 0, 0, 0); chk("dn_b4", B, 4); chk("dn_g4", G, 4'h6);
    tick(0, 1, 0, 0, 0); chk("dn_b3", B, 3); chk("dn_g3", G, 4'h2);
    tick(0, 1, 0, 0, 0); chk("dn_b2", B, 2); chk("dn_g2", G, 4'h3);
    tick(0, 1, 0, 0, 0); chk("dn_b1", B, 1); chk("dn_wrap1", wrap, 0);
    tick(0, 1, 0, 0, 0); chk("dn_b0", B, 0); chk("tc_at_0", tc, 1);
    tick(0, 1, 0, 0, 0);
    chk("dn_wrap_b", B, SAT ? 0 : 15);
    chk("dn_wrap_g", G, SAT ? 0 : 8);
    chk("dn_wrap_pulse", wrap, 1);
    tick(0, 1, 1, 0, 0);
    chk("dir_change_wrap", wrap, SAT ? 0 : 1);
    chk("dir_change_b", B, SAT ? 1 : 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) tick(0, 1, 1, 0, 0);
    chk("count_to_9", B, 9);
    tick(1, 1, 1, 0, 0);
    chk("mid_rst_b", B, 0);
    chk("mid_rst_g", G, 0);
    chk("mid_rst_wrap", wrap, 0);
    tick(0, 1, 1, 0, 0);
    chk("resume_b", B, 1);
    tick(0, 0, 1, 1, 4'hF);
    tick(0, 1, 1, 1, 4'h3);
    chk("load_over_en_b", B, 3);
    chk("load_over_en_wrap", wrap, 0);
`ifdef GRAY_COUNTER_SATURATE_EN
    tick(0, 0, 1, 1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 0, 0);
      chk("sat_up_b", B, 15);
      chk("sat_up_wrap", wrap, 1);
    end
    tick(0, 0, 0, 1, 4'h0);
    tick(0, 1, 0, 0, 0);
    chk("sat_dn_b", B, 0);
    chk("sat_dn_wrap", wrap, 1);
`endif
    for (int i = 0; i < 1000; i++)
      tick($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0, 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
